regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Next-generation processor register file: parametrised width/depth, NRD read ports, one write port.
//  Adds same-cycle write-to-read bypass, an optional hardwired zero register and a per-register
//  scoreboard (busy bits) for hazard detection in a pipelined core.
//  Sits between decode (reads, reserves) and writeback (writes, releases).
// PARAMETERS
//  DBITS   32  data width per register
//  ABITS   4   index width; WORDS = 1<<ABITS registers (indices 0..WORDS-1 only)
//  NRD     2   number of read ports (>=1)
//  ZERO_R0 1   1: register 0 reads as 0, ignores writes, never busy; 0: r0 is ordinary
// PORTS
//  clk     in   1            rising-edge clock
//  reset   in   1            asynchronous, active-high reset
//  wrtEn   in   1            writeback strobe
//  wrtInd  in   ABITS        writeback index
//  dIn     in   DBITS        writeback data
//  rsvEn   in   1            reserve strobe (issued instruction will write rsvInd)
//  rsvInd  in   ABITS        index to mark busy
//  rdInd   in   NRD*ABITS    read indices; port k = rdInd[k*ABITS +: ABITS]
//  dOut    out  NRD*DBITS    read data; port k = dOut[k*DBITS +: DBITS]
//  rdBusy  out  NRD          1 = port k's register has a pending, unresolved write
//  anyBusy out  1            OR of all busy bits
//  wawErr  out  1            sticky: reserve hit an already-busy register
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation): all registers = 0, all busy bits = 0, wawErr = 0.
//   Outputs then: dOut = 0 (or bypassed dIn), rdBusy = 0, anyBusy = 0. Releases on next clk edge.
//  Write: on posedge clk, wrtEn=1 -> reg[wrtInd] <= dIn and busy[wrtInd] <= 0 (release).
//   ZERO_R0=1 and wrtInd=0 -> no effect.
//  Reserve: on posedge clk, rsvEn=1 -> busy[rsvInd] <= 1. ZERO_R0=1 and rsvInd=0 -> ignored.
//   rsvEn=1 while busy[rsvInd]=1 (and not same-index release that cycle) -> wawErr <= 1 (sticky until reset).
//  Simultaneous wrtEn and rsvEn, same index: data written AND busy ends 1 (new reservation wins);
//   no wawErr (old reservation resolves that cycle). Different indices: both take effect.
//  Reads: combinational, zero latency, all NRD ports independent, any index may repeat.
//   dOut[k] = (wrtEn && wrtInd==idx_k && !(ZERO_R0 && idx_k==0)) ? dIn : reg[idx_k].
//   ZERO_R0=1 and idx_k=0 -> dOut[k] = 0 always.
//  Busy: rdBusy[k] = busy[idx_k] & ~(wrtEn && wrtInd==idx_k); releasing write hides hazard same cycle.
//   A reserve in the current cycle does not affect rdBusy until after the edge.
//  anyBusy = |busy (registered state only, no bypass).
//  No X on outputs after reset; out-of-range indices impossible (exactly WORDS entries).
// TESTING
//  1 reset: write 0xDEADBEEF to r5, assert reset mid-cycle -> dOut(r5)=0, rdBusy=0, anyBusy=0 immediately.
//  2 bypass: wrtEn=1,wrtInd=3,dIn=0x1234, rdInd0=3 same cycle -> dOut0=0x1234; next cycle, wrtEn=0 -> still 0x1234.
//  3 zero reg (ZERO_R0=1): write 0xFFFFFFFF to r0, reserve r0 -> dOut=0, rdBusy=0, anyBusy=0, wawErr=0.
//  4 scoreboard: reserve r7; next cycle read r7 -> rdBusy=1, anyBusy=1; write r7=0x55 -> same cycle rdBusy=0,
//    dOut=0x55; following cycle anyBusy=0.
//  5 collisions: r2 busy; same edge wrtInd=2 and rsvInd=2 -> r2 holds new data, rdBusy=1, wawErr=0;
//    then reserve r2 again without write -> wawErr=1 and stays 1 until reset.
//  6 multiport (NRD=3, ABITS=5): ports read r1,r1,r31 with r31 being written 0xA5A5A5A5 -> ports 0,1 equal
//    stored r1, port 2 = 0xA5A5A5A5; randomised ops vs. reference model for 10k cycles.

Source files
------------

// File: rtl/regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_mp_scoreboard
//
// Multi-ported processor register file with a per-register scoreboard.
// Decode reads operands combinationally and reserves the destination of each
// issued instruction; writeback writes the result and releases that
// reservation. A write in flight is bypassed to any read port that names the
// same register in the same cycle, so a consumer never sees stale data, and
// the matching busy bit is hidden at the same time.
//
// Parameters
//   DBITS   data width of each register
//   ABITS   index width, the file holds exactly 1<<ABITS registers
//   NRD     number of independent read ports
//   ZERO_R0 1: register 0 is hardwired to zero, ignores writes and
//           reservations and is never busy; 0: register 0 is ordinary
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset (clears data, busy bits, wawErr)
//   wrtEn    writeback strobe
//   wrtInd   writeback register index
//   dIn      writeback data
//   rsvEn    reserve strobe from issue
//   rsvInd   register index to mark busy
//   rdInd    packed read indices, port k = rdInd[k*ABITS +: ABITS]
//   dOut     packed read data,    port k = dOut[k*DBITS +: DBITS]
//   rdBusy   per read port: that register has an unresolved pending write
//   anyBusy  at least one register is reserved (registered state only)
//   wawErr   sticky: a reservation hit a register that was still busy
// ---------------------------------------------------------------------------
module regfile_mp_scoreboard #(
    parameter int DBITS   = 32,
    parameter int ABITS   = 4,
    parameter int NRD     = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrtEn,
    input  logic [ABITS-1:0]     wrtInd,
    input  logic [DBITS-1:0]     dIn,
    input  logic                 rsvEn,
    input  logic [ABITS-1:0]     rsvInd,
    input  logic [NRD*ABITS-1:0] rdInd,
    output logic [NRD*DBITS-1:0] dOut,
    output logic [NRD-1:0]       rdBusy,
    output logic                 anyBusy,
    output logic                 wawErr
);

    localparam int WORDS = 1 << ABITS;

    logic [DBITS-1:0] regs [WORDS];
    logic [WORDS-1:0] busy;
    logic             wawFlag;
    logic             wrtOk;
    logic             rsvOk;
    logic             sameInd;

    // A write or reservation aimed at the hardwired zero register is simply
    // dropped, which keeps r0 at zero and its busy bit permanently clear
    // without any special casing in the storage blocks below.
    assign wrtOk   = wrtEn && !(ZERO_R0 && (wrtInd == '0));
    assign rsvOk   = rsvEn && !(ZERO_R0 && (rsvInd == '0));
    assign sameInd = (wrtInd == rsvInd);

    // Register storage. Every entry is cleared on reset so that no read port
    // can ever return X after reset, even for registers never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                regs[i] <= '0;
            end
        end else if (wrtOk) begin
            regs[wrtInd] <= dIn;
        end
    end

    // Scoreboard busy bits. Writeback releases its register, issue reserves
    // one. The reserve assignment comes second so that when both name the
    // same register the new reservation survives the edge: the old producer
    // has just completed, the newly issued one is still outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (wrtOk) begin
                busy[wrtInd] <= 1'b0;
            end
            if (rsvOk) begin
                busy[rsvInd] <= 1'b1;
            end
        end
    end

    // Write-after-write detector. Reserving a register that already has an
    // outstanding producer means two writers in flight, which the pipeline
    // must never do. A release of that same register on the same edge
    // resolves the old producer, so that case is legal. Once raised the flag
    // stays up until reset so software or a debugger can find it later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wawFlag <= 1'b0;
        end else if (rsvOk && busy[rsvInd] && !(wrtOk && sameInd)) begin
            wawFlag <= 1'b1;
        end
    end

    assign wawErr  = wawFlag;
    assign anyBusy = |busy;

    // Read ports. Each port is independent. The hardwired zero has top
    // priority, then the same-cycle writeback bypass, then stored data. The
    // busy output is masked by a matching write because that write is
    // exactly the value the consumer was waiting for. A reservation made this
    // cycle is deliberately not visible here until after the clock edge.
    for (genvar k = 0; k < NRD; k++) begin : gRead
        logic [ABITS-1:0] idx;
        logic             wrtHit;

        assign idx    = rdInd[k*ABITS +: ABITS];
        assign wrtHit = wrtEn && (wrtInd == idx);

        assign dOut[k*DBITS +: DBITS] = (ZERO_R0 && (idx == '0)) ? '0 :
                                        (wrtHit ? dIn : regs[idx]);
        assign rdBusy[k] = busy[idx] & ~wrtHit;
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_scoreboard
//
// Self-checking bench for regfile_mp_scoreboard. Two instances are used:
//   dutA  default shape (2 read ports, 16 x 32 bit, hardwired r0)
//   dutB  3 read ports, 32 x 32 bit, ordinary r0
// A behavioural model holds each file's contents, its set of reserved
// registers and its sticky error flag, and is advanced once per clock edge
// from the inputs that were applied during that cycle.
// ---------------------------------------------------------------------------
module tb_regfile_mp_scoreboard;

    logic        clk;
    logic        reset;

    logic        aWrtEn;
    logic [3:0]  aWrtInd;
    logic [31:0] aDIn;
    logic        aRsvEn;
    logic [3:0]  aRsvInd;
    logic [7:0]  aRdInd;
    logic [63:0] aDOut;
    logic [1:0]  aRdBusy;
    logic        aAnyBusy;
    logic        aWawErr;

    logic        bWrtEn;
    logic [4:0]  bWrtInd;
    logic [31:0] bDIn;
    logic        bRsvEn;
    logic [4:0]  bRsvInd;
    logic [14:0] bRdInd;
    logic [95:0] bDOut;
    logic [2:0]  bRdBusy;
    logic        bAnyBusy;
    logic        bWawErr;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mem   [2][32];
    bit          busyM [2][32];
    bit          wawM  [2];
    bit          zeroR0 [2] = '{1'b1, 1'b0};
    int          words  [2] = '{16, 32};

    regfile_mp_scoreboard #(
        .DBITS(32), .ABITS(4), .NRD(2), .ZERO_R0(1'b1)
    ) dutA (
        .clk(clk), .reset(reset),
        .wrtEn(aWrtEn), .wrtInd(aWrtInd), .dIn(aDIn),
        .rsvEn(aRsvEn), .rsvInd(aRsvInd),
        .rdInd(aRdInd), .dOut(aDOut), .rdBusy(aRdBusy),
        .anyBusy(aAnyBusy), .wawErr(aWawErr)
    );

    regfile_mp_scoreboard #(
        .DBITS(32), .ABITS(5), .NRD(3), .ZERO_R0(1'b0)
    ) dutB (
        .clk(clk), .reset(reset),
        .wrtEn(bWrtEn), .wrtInd(bWrtInd), .dIn(bDIn),
        .rsvEn(bRsvEn), .rsvInd(bRsvInd),
        .rdInd(bRdInd), .dOut(bDOut), .rdBusy(bRdBusy),
        .anyBusy(bAnyBusy), .wawErr(bWawErr)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: everything forgotten on reset.
    task automatic modelClear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                mem[m][i]   = '0;
                busyM[m][i] = 1'b0;
            end
            wawM[m] = 1'b0;
        end
    endtask

    // Model: effect of one clock edge on one register file.
    task automatic modelStep(input int m, input bit we, input int wi,
                             input logic [31:0] d, input bit re, input int ri);
        bit wOk;
        bit rOk;
        wOk = we && !(zeroR0[m] && wi == 0);
        rOk = re && !(zeroR0[m] && ri == 0);
        if (rOk && busyM[m][ri] && !(wOk && wi == ri)) wawM[m] = 1'b1;
        if (wOk) begin
            mem[m][wi]   = d;
            busyM[m][wi] = 1'b0;
        end
        if (rOk) busyM[m][ri] = 1'b1;
    endtask

    // Model: what a read port should show given this cycle's write.
    function automatic logic [31:0] modelRead(input int m, input bit we, input int wi,
                                              input logic [31:0] d, input int idx);
        if (zeroR0[m] && idx == 0) return 32'h0;
        if (we && wi == idx) return d;
        return mem[m][idx];
    endfunction

    function automatic bit modelBusy(input int m, input bit we, input int wi, input int idx);
        return busyM[m][idx] && !(we && wi == idx);
    endfunction

    function automatic bit modelAny(input int m);
        bit any;
        any = 1'b0;
        for (int i = 0; i < words[m]; i++) any = any | busyM[m][i];
        return any;
    endfunction

    // Let the pending inputs of both files take effect on the next rising
    // edge and leave the bench 1 ns past that edge.
    task automatic applyStimulus();
        modelStep(0, aWrtEn, int'(aWrtInd), aDIn, aRsvEn, int'(aRsvInd));
        modelStep(1, bWrtEn, int'(bWrtInd), bDIn, bRsvEn, int'(bRsvInd));
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        aWrtEn = 1'b0; aWrtInd = '0; aDIn = '0; aRsvEn = 1'b0; aRsvInd = '0; aRdInd = '0;
        bWrtEn = 1'b0; bWrtInd = '0; bDIn = '0; bRsvEn = 1'b0; bRsvInd = '0; bRdInd = '0;
    endtask

    // Reset state, then an asynchronous reset in the middle of a cycle.
    task automatic test_reset();
        #2;
        vectors++;
        if (aDOut !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_a_dout got=%h exp=%h", aDOut, 64'h0);
        end
        vectors++;
        if (bDOut !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_b_dout got=%h exp=%h", bDOut, 96'h0);
        end
        vectors++;
        if ({aRdBusy, aAnyBusy, aWawErr} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_a_flags got=%b exp=%b", {aRdBusy, aAnyBusy, aWawErr}, 4'b0);
        end
        @(negedge clk);
        reset = 1'b0;

        aRsvEn = 1'b1; aRsvInd = 4'd6;
        applyStimulus();
        aRsvEn = 1'b0;
        aWrtEn = 1'b1; aWrtInd = 4'd5; aDIn = 32'hDEADBEEF;
        applyStimulus();
        aWrtEn = 1'b0;
        aRdInd = {4'd6, 4'd5};
        #1;
        vectors++;
        if (aDOut[31:0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_r5 got=%h exp=%h", aDOut[31:0], 32'hDEADBEEF);
        end
        vectors++;
        if (aRdBusy !== 2'b10 || aAnyBusy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_busy got=%b/%b exp=10/1", aRdBusy, aAnyBusy);
        end
        #1;
        reset = 1'b1;
        modelClear();
        #1;
        vectors++;
        if (aDOut !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL midcycle_reset_dout got=%h exp=%h", aDOut, 64'h0);
        end
        vectors++;
        if (aRdBusy !== 2'b00 || aAnyBusy !== 1'b0 || aWawErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midcycle_reset_flags got=%b%b%b exp=000", aRdBusy, aAnyBusy, aWawErr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Same-cycle write bypass, then the value held once stored.
    task automatic test_bypass();
        aWrtEn = 1'b1; aWrtInd = 4'd3; aDIn = 32'h00001234;
        aRdInd = {4'd0, 4'd3};
        #1;
        vectors++;
        if (aDOut[31:0] !== 32'h00001234) begin
            miscompares++;
            $display("[TB] FAIL bypass_same_cycle got=%h exp=%h", aDOut[31:0], 32'h00001234);
        end
        applyStimulus();
        aWrtEn = 1'b0;
        #1;
        vectors++;
        if (aDOut[31:0] !== 32'h00001234) begin
            miscompares++;
            $display("[TB] FAIL bypass_stored got=%h exp=%h", aDOut[31:0], 32'h00001234);
        end
    endtask

    // Hardwired zero register ignores writes and reservations.
    task automatic test_zero_reg();
        aWrtEn = 1'b1; aWrtInd = 4'd0; aDIn = 32'hFFFFFFFF;
        aRsvEn = 1'b1; aRsvInd = 4'd0;
        aRdInd = {4'd0, 4'd0};
        #1;
        vectors++;
        if (aDOut !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL zero_no_bypass got=%h exp=%h", aDOut, 64'h0);
        end
        applyStimulus();
        aWrtEn = 1'b0;
        applyStimulus();
        aRsvEn = 1'b0;
        #1;
        vectors++;
        if (aDOut !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL zero_stored got=%h exp=%h", aDOut, 64'h0);
        end
        vectors++;
        if (aRdBusy !== 2'b00 || aAnyBusy !== 1'b0 || aWawErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_flags got=%b%b%b exp=000", aRdBusy, aAnyBusy, aWawErr);
        end
    endtask

    // Reserve, observe the hazard, release it with a bypassed write.
    task automatic test_scoreboard();
        aRsvEn = 1'b1; aRsvInd = 4'd7;
        aRdInd = {4'd0, 4'd7};
        #1;
        vectors++;
        if (aRdBusy[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rsv_not_visible_yet got=%b exp=0", aRdBusy[0]);
        end
        applyStimulus();
        aRsvEn = 1'b0;
        #1;
        vectors++;
        if (aRdBusy[0] !== 1'b1 || aAnyBusy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL r7_busy got=%b/%b exp=1/1", aRdBusy[0], aAnyBusy);
        end
        aWrtEn = 1'b1; aWrtInd = 4'd7; aDIn = 32'h00000055;
        #1;
        vectors++;
        if (aRdBusy[0] !== 1'b0 || aDOut[31:0] !== 32'h00000055 || aAnyBusy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL r7_release got=%b/%h/%b exp=0/00000055/1",
                     aRdBusy[0], aDOut[31:0], aAnyBusy);
        end
        applyStimulus();
        aWrtEn = 1'b0;
        #1;
        vectors++;
        if (aAnyBusy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL r7_anybusy_cleared got=%b exp=0", aAnyBusy);
        end
    endtask

    // Release and re-reserve on one edge, then a genuine double reservation.
    task automatic test_collision();
        aRsvEn = 1'b1; aRsvInd = 4'd2;
        applyStimulus();
        aWrtEn = 1'b1; aWrtInd = 4'd2; aDIn = 32'hCAFE0002;
        applyStimulus();
        aWrtEn = 1'b0; aRsvEn = 1'b0;
        aRdInd = {4'd0, 4'd2};
        #1;
        vectors++;
        if (aDOut[31:0] !== 32'hCAFE0002 || aRdBusy[0] !== 1'b1 || aWawErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL collide_same_edge got=%h/%b/%b exp=cafe0002/1/0",
                     aDOut[31:0], aRdBusy[0], aWawErr);
        end
        aRsvEn = 1'b1; aRsvInd = 4'd2;
        applyStimulus();
        aRsvEn = 1'b0;
        #1;
        vectors++;
        if (aWawErr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL waw_raised got=%b exp=1", aWawErr);
        end
        aWrtEn = 1'b1; aWrtInd = 4'd2; aDIn = 32'h00000001;
        applyStimulus();
        aWrtEn = 1'b0;
        applyStimulus();
        vectors++;
        if (aWawErr !== 1'b1 || aAnyBusy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL waw_sticky got=%b/%b exp=1/0", aWawErr, aAnyBusy);
        end
        reset = 1'b1;
        modelClear();
        #1;
        vectors++;
        if (aWawErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL waw_reset got=%b exp=0", aWawErr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Three ports on the wide instance, repeated index plus a bypass.
    task automatic test_multiport();
        bWrtEn = 1'b1; bWrtInd = 5'd1; bDIn = 32'h11110001;
        applyStimulus();
        bWrtInd = 5'd31; bDIn = 32'hA5A5A5A5;
        bRdInd = {5'd31, 5'd1, 5'd1};
        #1;
        vectors++;
        if (bDOut !== {32'hA5A5A5A5, 32'h11110001, 32'h11110001}) begin
            miscompares++;
            $display("[TB] FAIL multiport_read got=%h exp=%h", bDOut,
                     {32'hA5A5A5A5, 32'h11110001, 32'h11110001});
        end
        applyStimulus();
        bWrtInd = 5'd0; bDIn = 32'h0BADF00D;
        applyStimulus();
        bWrtEn = 1'b0;
        bRdInd = {5'd31, 5'd1, 5'd0};
        #1;
        vectors++;
        if (bDOut !== {32'hA5A5A5A5, 32'h11110001, 32'h0BADF00D}) begin
            miscompares++;
            $display("[TB] FAIL ordinary_r0 got=%h exp=%h", bDOut,
                     {32'hA5A5A5A5, 32'h11110001, 32'h0BADF00D});
        end
    endtask

    // Random traffic on both instances against the model, with occasional
    // asynchronous resets dropped into the middle of a cycle.
    task automatic test_random();
        bit          narrow;
        logic [31:0] expD;
        logic [2:0]  expBusy;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            aWrtEn  = 1'($urandom_range(0, 1));
            aWrtInd = 4'($urandom_range(0, 15));
            aDIn    = $urandom;
            aRsvEn  = ($urandom_range(0, 3) == 0);
            aRsvInd = 4'($urandom_range(0, 15));
            aRdInd  = 8'($urandom);
            narrow  = 1'($urandom_range(0, 1));
            bWrtEn  = 1'($urandom_range(0, 1));
            bWrtInd = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            bDIn    = $urandom;
            bRsvEn  = ($urandom_range(0, 3) == 0);
            bRsvInd = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            for (int k = 0; k < 3; k++) begin
                bRdInd[k*5 +: 5] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            end
            #1;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                modelClear();
                #1;
            end

            expBusy = '0;
            for (int k = 0; k < 2; k++) begin
                expD = modelRead(0, aWrtEn, int'(aWrtInd), aDIn, int'(aRdInd[k*4 +: 4]));
                expBusy[k] = modelBusy(0, aWrtEn, int'(aWrtInd), int'(aRdInd[k*4 +: 4]));
                vectors++;
                if (aDOut[k*32 +: 32] !== expD) begin
                    miscompares++;
                    $display("[TB] FAIL rand_a_dout%0d cyc=%0d got=%h exp=%h",
                             k, cyc, aDOut[k*32 +: 32], expD);
                end
            end
            vectors++;
            if ({aRdBusy, aAnyBusy, aWawErr} !== {expBusy[1:0], modelAny(0), wawM[0]}) begin
                miscompares++;
                $display("[TB] FAIL rand_a_flags cyc=%0d got=%b exp=%b", cyc,
                         {aRdBusy, aAnyBusy, aWawErr}, {expBusy[1:0], modelAny(0), wawM[0]});
            end

            expBusy = '0;
            for (int k = 0; k < 3; k++) begin
                expD = modelRead(1, bWrtEn, int'(bWrtInd), bDIn, int'(bRdInd[k*5 +: 5]));
                expBusy[k] = modelBusy(1, bWrtEn, int'(bWrtInd), int'(bRdInd[k*5 +: 5]));
                vectors++;
                if (bDOut[k*32 +: 32] !== expD) begin
                    miscompares++;
                    $display("[TB] FAIL rand_b_dout%0d cyc=%0d got=%h exp=%h",
                             k, cyc, bDOut[k*32 +: 32], expD);
                end
            end
            vectors++;
            if ({bRdBusy, bAnyBusy, bWawErr} !== {expBusy, modelAny(1), wawM[1]}) begin
                miscompares++;
                $display("[TB] FAIL rand_b_flags cyc=%0d got=%b exp=%b", cyc,
                         {bRdBusy, bAnyBusy, bWawErr}, {expBusy, modelAny(1), wawM[1]});
            end

            reset = 1'b0;
            applyStimulus();
        end
    endtask

    // Scenario sequence.
    initial begin
        reset = 1'b1;
        idleInputs();
        modelClear();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_multiport();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
